keypad_scanner: RTL and testbench



---
 rtl/calc_pkg.sv | 46 ++++
 rtl/key_classifier.sv | 31 +++
 rtl/keypad_scanner.sv | 187 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad front end: matrix geometry,
// key meanings, scanner state encoding and snapshot classes.
package calc_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KEYS = ROWS * COLS;

  // Key code is {row[1:0], col[1:0]}; the constants name what each position means.
  localparam logic [3:0] KEY_0   = 4'h0;
  localparam logic [3:0] KEY_1   = 4'h1;
  localparam logic [3:0] KEY_2   = 4'h2;
  localparam logic [3:0] KEY_3   = 4'h3;
  localparam logic [3:0] KEY_4   = 4'h4;
  localparam logic [3:0] KEY_5   = 4'h5;
  localparam logic [3:0] KEY_6   = 4'h6;
  localparam logic [3:0] KEY_7   = 4'h7;
  localparam logic [3:0] KEY_8   = 4'h8;
  localparam logic [3:0] KEY_9   = 4'h9;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_DOT = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } key_class_e;

  // Active-low row drive pattern for a given row index.
  function automatic logic [ROWS-1:0] row_drive(input logic [1:0] idx);
    logic [ROWS-1:0] one_hot;
    one_hot = 4'b0001;
    return ~(one_hot << idx);
  endfunction

endpackage

// File: rtl/key_classifier.sv
// Combinational classification of a full-matrix snapshot into none, exactly
// one key (with its code) or several keys.
module key_classifier
  import calc_pkg::*;
(
  input  logic [KEYS-1:0] snapshot_i,
  output logic [1:0]      class_o,
  output logic [3:0]      code_o
);

  logic [4:0] count;

  always_comb begin
    count  = 5'd0;
    code_o = 4'd0;
    for (int i = 0; i < KEYS; i++) begin
      if (snapshot_i[i]) begin
        count  = count + 5'd1;
        code_o = 4'(i);
      end
    end
    if (count == 5'd0) begin
      class_o = CLS_NONE;
    end else if (count == 5'd1) begin
      class_o = CLS_SINGLE;
    end else begin
      class_o = CLS_MULTI;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: row drive, column synchronizer, per-scan snapshot,
// press/release debounce with ghost rejection, and a valid/ack key handoff.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 10000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic [ROWS-1:0] rows,
  input  logic [COLS-1:0] columns,
  output logic            key_valid,
  output logic [3:0]      key_code,
  input  logic            key_ack,
  output logic            overrun
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  logic [COLS-1:0] col_meta_q, col_sync_q;
  logic [CW-1:0]   slot_cnt_q;
  logic [1:0]      row_idx_q;
  logic [ROWS-1:0] rows_q;
  logic [KEYS-1:0] snapshot_q, snapshot_d;
  scan_state_e     state_q;
  logic [3:0]      cand_q, cnt_q, rel_q;
  logic            key_valid_q, overrun_q;
  logic [3:0]      key_code_q;
  logic            sample_pt, scan_end;
  logic [1:0]      cls_class;
  logic [3:0]      cls_code;
  logic            emit_d;
  logic [3:0]      emit_code_d;

  assign rows      = rows_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overrun   = overrun_q;

  // Columns are raw board pins; idle level (no key) is all ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= columns;
      col_sync_q <= col_meta_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt_q <= '0;
      row_idx_q  <= 2'd0;
      rows_q     <= 4'b1110;
    end else if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_q <= '0;
      row_idx_q  <= row_idx_q + 2'd1;
      rows_q     <= row_drive(row_idx_q + 2'd1);
    end else begin
      slot_cnt_q <= slot_cnt_q + CW'(1);
    end
  end

  assign sample_pt = (slot_cnt_q == SLOT_LAST);
  assign scan_end  = sample_pt && (row_idx_q == 2'd3);

  // The row being sampled this cycle is merged in so scan end sees all 16 keys.
  always_comb begin
    snapshot_d = snapshot_q;
    if (sample_pt) begin
      snapshot_d[{row_idx_q, 2'b00} +: COLS] = ~col_sync_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snapshot_q <= '0;
    end else begin
      snapshot_q <= snapshot_d;
    end
  end

  key_classifier u_classifier (
    .snapshot_i (snapshot_d),
    .class_o    (cls_class),
    .code_o     (cls_code)
  );

  always_comb begin
    emit_d      = 1'b0;
    emit_code_d = cand_q;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (cls_class == CLS_SINGLE && DEBOUNCE_SCANS == 1) begin
            emit_d      = 1'b1;
            emit_code_d = cls_code;
          end
        end
        DEBOUNCE: begin
          if (cls_class == CLS_SINGLE && cls_code == cand_q &&
              (cnt_q + 4'd1) == DB_TARGET) begin
            emit_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      rel_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      overrun_q   <= 1'b0;
    end else begin
      if (scan_end) begin
        case (state_q)
          IDLE: begin
            if (cls_class == CLS_SINGLE) begin
              cand_q  <= cls_code;
              rel_q   <= 4'd0;
              cnt_q   <= (DEBOUNCE_SCANS == 1) ? 4'd0 : 4'd1;
              state_q <= (DEBOUNCE_SCANS == 1) ? HELD : DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (cls_class == CLS_SINGLE && cls_code == cand_q) begin
              if (emit_d) begin
                state_q <= HELD;
                cnt_q   <= 4'd0;
                rel_q   <= 4'd0;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              state_q <= IDLE;
              cnt_q   <= 4'd0;
            end
          end
          HELD: begin
            // Ghosted (multi-key) snapshots still count as "something held".
            if (cls_class == CLS_NONE) begin
              if ((rel_q + 4'd1) == DB_TARGET) begin
                state_q <= IDLE;
                rel_q   <= 4'd0;
              end else begin
                rel_q <= rel_q + 4'd1;
              end
            end else begin
              rel_q <= 4'd0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rel_q   <= 4'd0;
          end
        endcase
      end

      if (emit_d) begin
        if (!key_valid_q || key_ack) begin
          key_code_q  <= emit_code_d;
          key_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (key_ack && key_valid_q) begin
        key_valid_q <= 1'b0;
      end

      if (key_ack) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: simulated key matrix on the pins, a scan-level
// behavioural model, per-cycle output comparison and directed plus random stimulus.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int SCAN = 4 * SD;
  localparam int LAT = (DB + 1) * SCAN + 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] columns;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ack = 1'b0;
  logic       overrun;
  logic [15:0] keys = 16'h0;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .rows      (rows),
    .columns   (columns),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ack   (key_ack),
    .overrun   (overrun)
  );

  // Physical matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    columns = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (rows[r] == 1'b0 && keys[r*4+c]) columns[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_t;
  logic [15:0] m_snap;
  int         m_streak, m_quiet;
  bit         m_held;
  logic [3:0] m_cand;
  logic       m_valid, m_ovr;
  logic [3:0] m_code;
  logic [3:0] m_d1, m_d2;
  logic [3:0] m_rows;

  always @(posedge clock) begin
    int r, n, k;
    logic [3:0] now, used, one;
    bit emit;
    if (reset) begin
      m_t = 0; m_snap = 16'h0; m_streak = 0; m_quiet = 0; m_held = 0;
      m_cand = 4'h0; m_valid = 0; m_ovr = 0; m_code = 4'h0;
      m_d1 = 4'hF; m_d2 = 4'hF; m_rows = 4'b1110;
    end else begin
      r = (m_t / SD) % 4;
      now = 4'hF;
      for (int c = 0; c < 4; c++) if (keys[r*4+c]) now[c] = 1'b0;
      used = m_d2; m_d2 = m_d1; m_d1 = now;
      emit = 0;
      if (m_t % SD == SD - 1) begin
        m_snap[r*4 +: 4] = ~used;
        if (r == 3) begin
          n = $countones(m_snap);
          k = 0;
          for (int i = 0; i < 16; i++) if (m_snap[i]) k = i;
          if (!m_held) begin
            if (m_streak > 0) begin
              if (n == 1 && 4'(k) == m_cand) m_streak++;
              else m_streak = 0;
            end else if (n == 1) begin
              m_cand = 4'(k);
              m_streak = 1;
            end
            if (m_streak == DB) begin
              emit = 1; m_held = 1; m_streak = 0; m_quiet = 0;
            end
          end else begin
            if (n == 0) m_quiet++;
            else m_quiet = 0;
            if (m_quiet == DB) begin
              m_held = 0; m_quiet = 0;
            end
          end
        end
      end
      if (emit) begin
        if (!m_valid || key_ack) begin
          m_code = m_cand; m_valid = 1;
          $display("key 0x%h delivered at %0t", m_cand, $time);
        end else begin
          m_ovr = 1;
          $display("key 0x%h dropped (overrun) at %0t", m_cand, $time);
        end
      end else if (key_ack && m_valid) begin
        m_valid = 0;
      end
      if (key_ack) m_ovr = 0;
      m_t++;
      one = 4'b0001;
      m_rows = ~(one << ((m_t / SD) % 4));
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("rows", rows, m_rows);
      chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
      chk("key_code", key_code, m_code);
      chk("overrun", {3'b0, overrun}, {3'b0, m_ovr});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (key_valid) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: key_valid got 0 after %0d cycles, expected 1", name, budget);
    end
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("reset_rows", rows, 4'b1110);
    chk("reset_valid", {3'b0, key_valid}, 4'h0);
    check_en = 1'b1;
    reset = 1'b0;

    // Idle scanning
    tick(100);
    chk("idle_valid", {3'b0, key_valid}, 4'h0);

    // Single key 0xA, ack, no repeat while held
    keys = 16'h0400;
    wait_valid("latency_A", LAT);
    chk("code_A", key_code, 4'hA);
    ack_pulse();
    chk("ack_clears", {3'b0, key_valid}, 4'h0);
    tick(64);
    chk("no_repeat", {3'b0, key_valid}, 4'h0);
    keys = 16'h0; tick(64);

    // One-scan pulse is rejected
    keys = 16'h0080; tick(SCAN);
    keys = 16'h0; tick(80);
    chk("pulse_reject", {3'b0, key_valid}, 4'h0);

    // Ghosting: 5 and 6 together, then release 6
    keys = 16'h0060; tick(80);
    chk("multi_reject", {3'b0, key_valid}, 4'h0);
    keys = 16'h0020;
    wait_valid("latency_5", LAT);
    chk("code_5", key_code, 4'h5);
    ack_pulse();
    keys = 16'h0; tick(64);

    // Overrun: 3 pending, 9 confirmed without ack
    keys = 16'h0008;
    wait_valid("latency_3", LAT);
    tick(20);
    keys = 16'h0; tick(64);
    keys = 16'h0200; tick(64);
    chk("overrun_code", key_code, 4'h3);
    chk("overrun_set", {3'b0, overrun}, 4'h1);
    ack_pulse();
    chk("overrun_ack_valid", {3'b0, key_valid}, 4'h0);
    chk("overrun_ack_clear", {3'b0, overrun}, 4'h0);
    keys = 16'h0; tick(64);

    // Reset while debouncing
    keys = 16'h0002; tick(22);
    reset = 1'b1; tick(1);
    chk("rst_db_rows", rows, 4'b1110);
    chk("rst_db_code", key_code, 4'h0);
    reset = 1'b0;
    // Reset while a key is pending
    wait_valid("latency_1", LAT);
    reset = 1'b1; tick(1);
    chk("rst_kv_valid", {3'b0, key_valid}, 4'h0);
    chk("rst_kv_code", key_code, 4'h0);
    chk("rst_kv_rows", rows, 4'b1110);
    reset = 1'b0;
    keys = 16'h0; tick(64);

    // Random keys and acks
    for (int seg = 0; seg < 60; seg++) begin
      int mode, hold;
      logic [15:0] kv;
      mode = $urandom_range(0, 3);
      kv = 16'h0;
      if (mode == 1 || mode == 2) kv[$urandom_range(0, 15)] = 1'b1;
      if (mode == 3) begin
        kv[$urandom_range(0, 15)] = 1'b1;
        kv[$urandom_range(0, 15)] = 1'b1;
      end
      keys = kv;
      hold = $urandom_range(8, 60);
      for (int i = 0; i < hold; i++) begin
        key_ack = ($urandom_range(0, 7) == 0);
        tick(1);
      end
    end
    key_ack = 1'b0; keys = 16'h0;
    tick(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
